ram_bist: RTL
=============

# ram_bist

Built-in self-test engine for the single-port synchronous RAM: it is the initiator on the RAM's write/address/read-data interface. On a start pulse it runs a March C- sequence over every word, compares read data against expected values, and reports pass/fail with first-failure capture and an error count. It sits between the RAM and test/status logic and owns the RAM port while busy.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 6, RAM address width
- DEPTH, 32, number of words tested (addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W)
- BG, 8'h00, background pattern P (inverse ~P is the second pattern)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  begin test (sampled in IDLE or DONE only)
- ram_address  out  ADDR_W  address to RAM
- ram_wdata  out  DATA_W  write data to RAM
- ram_write_enable  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM read data (valid the cycle after a read address is presented with write_enable=0)
- busy  out  1  test in progress
- done  out  1  test finished; held until next start or rst
- fail  out  1  at least one miscompare this run
- fail_addr  out  ADDR_W  address of first miscompare
- fail_expected  out  DATA_W  expected value of first miscompare
- fail_actual  out  DATA_W  read value of first miscompare
- err_count  out  8  miscompare count, saturates at 255

## Operation
- States: IDLE, M0_WR, RD, CHK, DONE.
- March elements (E = element index 0..5):
  - E0 ascending: write P
  - E1 ascending: read P, write ~P
  - E2 ascending: read ~P, write P
  - E3 descending: read P, write ~P
  - E4 descending: read ~P, write P
  - E5 descending: read P
- M0_WR: one cycle per address, we=1, wdata=P; after address DEPTH-1 -> RD with E=1, address 0.
- RD: we=0, drive current address (RAM registers it). Always -> CHK.
- CHK: same address driven; compare ram_rdata with expected. E1-E4: we=1, wdata = element's write value (RAM still outputs old contents this cycle, so compare and write coexist). E5: we=0.
- CHK exit: if address is element's last (DEPTH-1 ascending, 0 descending) -> advance E; E3 starts at DEPTH-1; after E5 -> DONE. Otherwise step address (+1 / -1) -> RD.
- Miscompare in CHK: err_count += 1 (saturating); if fail==0, set fail=1 and capture fail_addr/expected/actual. Test always runs to completion.
- IDLE/DONE: ram_address=0, ram_wdata=0, we=0. start in IDLE or DONE: clear fail, fail_*, err_count, done; enter M0_WR at address 0. start while busy ignored.

## Timing
- Reset values: busy=0, done=0, fail=0, fail_addr=0, fail_expected=0, fail_actual=0, err_count=0, ram_address=0, ram_wdata=0, ram_write_enable=0; state IDLE.
- rst mid-run: next edge returns to reset values; RAM contents undefined; no partial status retained.
- start sampled at edge T; busy=1 from T+1; first write (addr 0, P) driven in cycle T+1.
- Cycle budget: E0 = DEPTH; E1-E5 = 2·DEPTH each; total busy = 11·DEPTH (352 at DEPTH=32).
- done=1, busy=0 the cycle after last E5 CHK; status outputs stable while done.
- All outputs registered; no combinational path from ram_rdata to outputs.
- err_count at 255 stays 255; fail capture fires only once per run.

## Test plan
- Healthy RAM model, DEPTH=32, BG=00: start pulse -> busy exactly 352 cycles, then done=1, fail=0, err_count=0.
- Bus trace: cycles 1-32 of busy show we=1, addr 0..31, wdata 00; cycle 33 we=0 addr 0; cycle 34 we=1 addr 0 wdata FF; first E3 access addr 31.
- Model with addr 5 bit0 stuck-at-1 -> fail=1, fail_addr=5, fail_expected=00, fail_actual=01, err_count=3 (E1, E3, E5).
- Model where every read returns 8'hAA -> err_count=160 (5·32 reads), fail_addr=0, expected 00, actual AA.
- rst asserted at busy cycle 100 -> next cycle all outputs at reset values; new start completes 352 cycles with fail=0.
- start pulsed at busy cycle 50 -> ignored, total still 352; start while done after failing run -> fail, err_count, done cleared next cycle, busy=1.

Source files
------------

// File: rtl/ram_bist.sv
// March C- built-in self-test engine for a single-port synchronous RAM.
// Drives the RAM port while busy and reports first-failure capture and a saturating error count.
module ram_bist #(
  parameter int              DATA_W = 8,
  parameter int              ADDR_W = 6,
  parameter int              DEPTH  = 32,
  parameter logic [DATA_W-1:0] BG   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_expected,
  output logic [DATA_W-1:0] fail_actual,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    IDLE,
    M0_WR,
    RD,
    CHK,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [2:0]        E5   = 3'd5;

  state_t              state;
  logic [2:0]          elem;
  logic [DATA_W-1:0]   exp_val;
  logic                descending;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   next_start;
  logic                miscompare;

  // Odd elements read the background, even ones its inverse; each writes back the opposite.
  always_comb begin
    exp_val    = (elem[0]) ? BG : ~BG;
    descending = (elem >= 3'd3);
    last_addr  = descending ? '0 : LAST;
    next_start = (elem >= 3'd2) ? LAST : '0;
    miscompare = (ram_rdata != exp_val);
  end

  // NOTE: all state and outputs are registers updated with non-blocking assignments,
  // so every branch below sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      elem             <= '0;
      ram_address      <= '0;
      ram_wdata        <= '0;
      ram_write_enable <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fail             <= 1'b0;
      fail_addr        <= '0;
      fail_expected    <= '0;
      fail_actual      <= '0;
      err_count        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= M0_WR;
            elem             <= '0;
            ram_address      <= '0;
            ram_wdata        <= BG;
            ram_write_enable <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            fail             <= 1'b0;
            fail_addr        <= '0;
            fail_expected    <= '0;
            fail_actual      <= '0;
            err_count        <= '0;
          end
        end

        M0_WR: begin
          if (ram_address == LAST) begin
            state            <= RD;
            elem             <= 3'd1;
            ram_address      <= '0;
            ram_wdata        <= '0;
            ram_write_enable <= 1'b0;
          end else begin
            ram_address <= ram_address + ONE;
          end
        end

        RD: begin
          // The write-back shares the CHK cycle: the RAM still presents the old word then.
          state            <= CHK;
          ram_write_enable <= (elem != E5);
          ram_wdata        <= (elem != E5) ? ~exp_val : '0;
        end

        CHK: begin
          ram_write_enable <= 1'b0;
          ram_wdata        <= '0;
          if (miscompare) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (!fail) begin
              fail          <= 1'b1;
              fail_addr     <= ram_address;
              fail_expected <= exp_val;
              fail_actual   <= ram_rdata;
            end
          end
          if (ram_address == last_addr) begin
            if (elem == E5) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              ram_address <= '0;
            end else begin
              state       <= RD;
              elem        <= elem + 3'd1;
              ram_address <= next_start;
            end
          end else begin
            state       <= RD;
            ram_address <= descending ? (ram_address - ONE) : (ram_address + ONE);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
